apb_master: RTL and testbench

Single-outstanding APB3 requester that converts a simple valid/ready command interface into APB SETUP/ACCESS phases and returns read data, slave error and completion to the requester. Sits directly upstream of the APB slave and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA, consuming PREADY/PRDATA/PSLVERR. It also bounds wait-states with a timeout counter, so a hung slave cannot stall the bus forever.

---
 rtl/apb_master_if.sv | 34 +++
 rtl/apb_master.sv | 124 ++++++++++++
 tb/tb_apb_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response and APB3 bus signals of the apb_master requester.
// The master modport is the block's own view; slave is the view of the surrounding logic.
`timescale 1ns/1ps
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: valid/ready command in, SETUP/ACCESS phases out,
// one-cycle response pulse back, with an optional wait-state timeout.
`timescale 1ns/1ps
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]        state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = ST_SETUP;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = bus.cmd_write;
          paddr_d    = bus.cmd_addr;
          pwdata_d   = bus.cmd_wdata;
          wait_cnt_d = '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // Completion is tested first so PREADY on the limit cycle beats the timeout.
        if (bus.PREADY) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
        end else if (TIMEOUT != 0 && wait_cnt_q == WAIT_LIMIT) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): table of single transfers plus
// hand-written reset, back-to-back and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  // Slave read data: scripted per vector, or address-derived for the back-to-back run.
  logic          slave_auto = 1'b0;
  logic [DW-1:0] prdata_drv = '0;
  assign bus.PRDATA = slave_auto ? (32'hC0DE_0000 | bus.PADDR) : prdata_drv;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    logic          slverr;
    int            waits;      // ACCESS cycles with PREADY low before it rises
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;    // cycles from accept edge to rsp_valid sample
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int   lat;
    logic stable;
    lat    = 0;
    stable = 1'b1;
    prdata_drv      = v.prdata;
    bus.PSLVERR     = v.slverr;
    bus.PREADY      = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = v.wr;
    bus.cmd_addr    = v.addr;
    bus.cmd_wdata   = v.wdata;
    check({v.name, ".ready_idle"}, 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    check({v.name, ".setup_psel"},    64'(bus.PSEL),    64'd1);
    check({v.name, ".setup_penable"}, 64'(bus.PENABLE), 64'd0);
    check({v.name, ".setup_paddr"},   64'(bus.PADDR),   64'(v.addr));
    check({v.name, ".setup_pwrite"},  64'(bus.PWRITE),  64'(v.wr));
    check({v.name, ".setup_pwdata"},  64'(bus.PWDATA),  64'(v.wdata));
    // Requester keeps cmd_valid up with different fields; they must be ignored while busy.
    bus.cmd_write = ~v.wr;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    for (int k = 1; k < 40; k++) begin
      // PREADY is also high in SETUP for zero-wait rows; it must be ignored there.
      bus.PREADY = (k >= 2 + v.waits) || (v.waits == 0);
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        lat = k + 1;
        break;
      end
      if (!(bus.PSEL && bus.PENABLE && bus.PADDR == v.addr &&
            bus.PWRITE == v.wr && bus.PWDATA == v.wdata))
        stable = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    check({v.name, ".latency"},     64'(lat),           64'(v.exp_lat));
    check({v.name, ".rsp_rdata"},   64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check({v.name, ".rsp_err"},     64'(bus.rsp_err),   64'(v.exp_err));
    check({v.name, ".ready_rsp"},   64'(bus.cmd_ready), 64'd1);
    check({v.name, ".psel_done"},   64'({bus.PSEL, bus.PENABLE}), 64'd0);
    check({v.name, ".access_stable"}, 64'(stable),      64'd1);
    @(posedge clk); #1;
    check({v.name, ".pulse_one"},   64'(bus.rsp_valid), 64'd0);
    check({v.name, ".rdata_hold"},  64'(bus.rsp_rdata), 64'(v.exp_rdata));
    check({v.name, ".err_hold"},    64'(bus.rsp_err),   64'(v.exp_err));
    check({v.name, ".paddr_hold"},  64'(bus.PADDR),     64'(v.addr));
    check({v.name, ".idle_psel"},   64'(bus.PSEL),      64'd0);
  endtask

  initial begin
    logic [AW-1:0] b2b_addr  [3];
    logic          b2b_wr    [3];
    logic [DW-1:0] b2b_wdata [3];
    logic [DW-1:0] b2b_exp   [3];
    int            setup_at  [$];
    int            rsp_at    [$];
    logic [DW-1:0] rsp_data  [$];
    int            idx;
    logic          accepted;

    vecs[0] = '{"rd_zero_wait", 1'b0, 32'h1, 32'h0,      32'hDEAD_BEEF, 1'b0, 0,  32'hDEAD_BEEF, 1'b0, 3};
    vecs[1] = '{"wr_two_wait",  1'b1, 32'h2, 32'h2,      32'h1234_5678, 1'b0, 2,  32'h0,         1'b0, 5};
    vecs[2] = '{"rd_slverr",    1'b0, 32'h3, 32'h0,      32'h0BAD_F00D, 1'b1, 0,  32'h0BAD_F00D, 1'b1, 3};
    vecs[3] = '{"rd_timeout",   1'b0, 32'h4, 32'h0,      32'hFFFF_FFFF, 1'b0, 99, 32'h0,         1'b1, 6};
    vecs[4] = '{"rd_limit_ok",  1'b0, 32'h5, 32'h0,      32'hA5A5_5A5A, 1'b0, 3,  32'hA5A5_5A5A, 1'b0, 6};
    vecs[5] = '{"wr_timeout",   1'b1, 32'h6, 32'hCAFE,   32'h1111_1111, 1'b1, 99, 32'h0,         1'b1, 6};
    vecs[6] = '{"wr_err_wait",  1'b1, 32'h7, 32'h77,     32'h2222_2222, 1'b1, 1,  32'h0,         1'b1, 4};

    // Reset held with a pending command: nothing may start.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h55;
    bus.cmd_wdata = 32'h66;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.psel",      64'(bus.PSEL),      64'd0);
    check("rst.penable",   64'(bus.PENABLE),   64'd0);
    check("rst.pwrite",    64'(bus.PWRITE),    64'd0);
    check("rst.paddr",     64'(bus.PADDR),     64'd0);
    check("rst.pwdata",    64'(bus.PWDATA),    64'd0);
    check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst.rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: cmd_valid held for three commands against a zero-wait slave.
    b2b_addr  = '{32'h1, 32'h2, 32'h3};
    b2b_wr    = '{1'b0, 1'b0, 1'b1};
    b2b_wdata = '{32'h0, 32'h0, 32'h2};
    b2b_exp   = '{32'hC0DE_0001, 32'hC0DE_0002, 32'h0};
    slave_auto    = 1'b1;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    idx           = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = b2b_wr[0];
    bus.cmd_addr  = b2b_addr[0];
    bus.cmd_wdata = b2b_wdata[0];
    for (int s = 1; s <= 11; s++) begin
      accepted = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (accepted) begin
        idx++;
        if (idx < 3) begin
          bus.cmd_write = b2b_wr[idx];
          bus.cmd_addr  = b2b_addr[idx];
          bus.cmd_wdata = b2b_wdata[idx];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (bus.PSEL && !bus.PENABLE) setup_at.push_back(s);
      if (bus.rsp_valid) begin
        rsp_at.push_back(s);
        rsp_data.push_back(bus.rsp_rdata);
      end
      if (s == 7) begin
        check("b2b.pwrite3", 64'(bus.PWRITE), 64'd1);
        check("b2b.pwdata3", 64'(bus.PWDATA), 64'h2);
        check("b2b.paddr3",  64'(bus.PADDR),  64'h3);
      end
    end
    check("b2b.setup_count", 64'(setup_at.size()), 64'd3);
    check("b2b.rsp_count",   64'(rsp_at.size()),   64'd3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b2b.setup_cycle%0d", j), 64'(j < setup_at.size() ? setup_at[j] : -1), 64'(1 + 3 * j));
      check($sformatf("b2b.rsp_cycle%0d", j),   64'(j < rsp_at.size()   ? rsp_at[j]   : -1), 64'(3 + 3 * j));
      check($sformatf("b2b.rsp_rdata%0d", j),   64'(j < rsp_data.size() ? rsp_data[j] : 32'hFFFF_FFFF), 64'(b2b_exp[j]));
    end
    slave_auto = 1'b0;
    bus.PREADY = 1'b0;

    // Reset asserted mid-ACCESS: bus drops at once, the transfer produces no response.
    prdata_drv    = 32'h9999_9999;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 32'h0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid.in_access", 64'({bus.PSEL, bus.PENABLE}), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("mid.psel_async",    64'(bus.PSEL),    64'd0);
    check("mid.penable_async", 64'(bus.PENABLE), 64'd0);
    bus.PREADY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        @(negedge clk);
        rst = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("mid.no_rsp%0d", c), 64'(bus.rsp_valid), 64'd0);
      check($sformatf("mid.no_psel%0d", c), 64'(bus.PSEL), 64'd0);
    end
    check("mid.ready_after", 64'(bus.cmd_ready), 64'd1);
    bus.PREADY = 1'b0;

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
